fpdiv_seq: RTL and testbench

FPDIV_SEQ -- requirements
Module: fpdiv_seq

---
 rtl/fpdiv_seq.sv | 136 +++++++++++++
 tb/tb_fpdiv_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_seq.sv
// Sequencer for a Goldschmidt divider datapath: steps the A/B operand muxes and the
// regA/regB/regC/regR load enables through initial approximation, refinement pairs and back-multiply.
module fpdiv_seq #(
  parameter int unsigned NUM_ITER = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       enA,
  output logic       enB,
  output logic       enC,
  output logic       enR,
  output logic       busy,
  output logic       done,
  output logic [2:0] iter
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StInitQ = 3'd1,
    StInitR = 3'd2,
    StIterQ = 3'd3,
    StIterR = 3'd4,
    StRem   = 3'd5,
    StDone  = 3'd6
  } state_e;

  localparam logic [2:0] LastIter = 3'(NUM_ITER - 1);

  state_e     state_q, state_d;
  logic [2:0] iter_q, iter_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      iter_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    // Abort outranks every other transition; in IDLE it also masks start.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      iter_d  = 3'd0;
    end else begin
      case (state_q)
        StIdle: begin
          iter_d = 3'd0;
          if (start && !abort) state_d = StInitQ;
        end
        StInitQ: state_d = StInitR;
        StInitR: begin
          state_d = StIterQ;
          iter_d  = 3'd0;
        end
        StIterQ: state_d = StIterR;
        StIterR: begin
          if (iter_q == LastIter) begin
            state_d = StRem;
            iter_d  = 3'd0;
          end else begin
            state_d = StIterQ;
            iter_d  = iter_q + 3'd1;
          end
        end
        StRem:   state_d = StDone;
        StDone:  state_d = StIdle;
        default: begin
          state_d = StIdle;
          iter_d  = 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    sel_muxa = 2'd0;
    sel_muxb = 2'd0;
    enA      = 1'b0;
    enB      = 1'b0;
    enC      = 1'b0;
    enR      = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      StInitQ: begin
        sel_muxa = 2'd2;
        sel_muxb = 2'd1;
        enB      = 1'b1;
        busy     = 1'b1;
      end
      StInitR: begin
        sel_muxa = 2'd2;
        sel_muxb = 2'd0;
        enA      = 1'b1;
        enC      = 1'b1;
        busy     = 1'b1;
      end
      StIterQ: begin
        sel_muxa = 2'd0;
        sel_muxb = 2'd2;
        enB      = 1'b1;
        busy     = 1'b1;
      end
      StIterR: begin
        sel_muxa = 2'd0;
        sel_muxb = 2'd3;
        enA      = 1'b1;
        enC      = 1'b1;
        busy     = 1'b1;
      end
      StRem: begin
        sel_muxa = 2'd1;
        sel_muxb = 2'd2;
        enR      = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign iter = iter_q;

endmodule

// File: tb/tb_fpdiv_seq.sv
// Scoreboard bench for fpdiv_seq: three instances (NUM_ITER = 3, 1, 7) share one stimulus stream
// and are compared every cycle against a position-in-divide reference model.
module tb_fpdiv_seq;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;

  logic [1:0] sa [3];
  logic [1:0] sb [3];
  logic       ea [3];
  logic       eb [3];
  logic       ec [3];
  logic       er [3];
  logic       bs [3];
  logic       dn [3];
  logic [2:0] it [3];

  fpdiv_seq #(.NUM_ITER(3)) u_dut3 (
    .clock(clk), .reset(rst), .start(start), .abort(abort),
    .sel_muxa(sa[0]), .sel_muxb(sb[0]), .enA(ea[0]), .enB(eb[0]), .enC(ec[0]), .enR(er[0]),
    .busy(bs[0]), .done(dn[0]), .iter(it[0])
  );

  fpdiv_seq #(.NUM_ITER(1)) u_dut1 (
    .clock(clk), .reset(rst), .start(start), .abort(abort),
    .sel_muxa(sa[1]), .sel_muxb(sb[1]), .enA(ea[1]), .enB(eb[1]), .enC(ec[1]), .enR(er[1]),
    .busy(bs[1]), .done(dn[1]), .iter(it[1])
  );

  fpdiv_seq #(.NUM_ITER(7)) u_dut7 (
    .clock(clk), .reset(rst), .start(start), .abort(abort),
    .sel_muxa(sa[2]), .sel_muxb(sb[2]), .enA(ea[2]), .enB(eb[2]), .enC(ec[2]), .enR(er[2]),
    .busy(bs[2]), .done(dn[2]), .iter(it[2])
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int inst;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   p[3];
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;

  function automatic int nit(int i);
    return (i == 0) ? 3 : (i == 1) ? 1 : 7;
  endfunction

  // {sel_muxa, sel_muxb, enA, enB, enC, enR, busy, done, iter}
  function automatic logic [12:0] act(int i);
    return {sa[i], sb[i], ea[i], eb[i], ec[i], er[i], bs[i], dn[i], it[i]};
  endfunction

  // Expected outputs from the position within a divide (0 = idle, 1 = first busy cycle).
  function automatic logic [12:0] exp_vec(int pp, int n);
    logic [12:0] v;
    int k;
    v = '0;
    if (pp == 1) v = {2'd2, 2'd1, 4'b0100, 2'b10, 3'd0};
    else if (pp == 2) v = {2'd2, 2'd0, 4'b1010, 2'b10, 3'd0};
    else if (pp >= 3 && pp <= 2 + 2 * n) begin
      k = pp - 3;
      if (k % 2 == 0) v = {2'd0, 2'd2, 4'b0100, 2'b10, 3'(k / 2)};
      else            v = {2'd0, 2'd3, 4'b1010, 2'b10, 3'(k / 2)};
    end
    else if (pp == 3 + 2 * n) v = {2'd1, 2'd2, 4'b0001, 2'b10, 3'd0};
    else if (pp == 4 + 2 * n) v = {2'd0, 2'd0, 4'b0000, 2'b11, 3'd0};
    return v;
  endfunction

  function automatic void cmp(string name, int i, logic [12:0] got, logic [12:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s inst=%0d cycle=%0d got=%h want=%h", name, i, cyc + 1, got, want);
    end
  endfunction

  function automatic int find(int i);
    for (int j = 0; j < sbq.size(); j++) if (sbq[j].inst == i) return j;
    return -1;
  endfunction

  function automatic void drop(int i);
    int j;
    j = find(i);
    if (j >= 0) sbq.delete(j);
  endfunction

  // Reference model: advances each instance's position on every rising edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        p[i] = 0;
        drop(i);
      end else if (p[i] == 0) begin
        if (start && !abort) begin
          p[i]   = 1;
          e.inst = i;
          e.cyc  = cyc + 4 + 2 * nit(i);
          sbq.push_back(e);
        end
      end else if (abort) begin
        p[i] = 0;
        drop(i);
      end else if (p[i] == 4 + 2 * nit(i)) begin
        p[i] = 0;
      end else begin
        p[i]++;
      end
    end
  end

  // Monitor: full output vector every cycle; done pulses are matched against the scoreboard.
  always @(negedge clk) begin
    int j;
    for (int i = 0; i < 3; i++) begin
      cmp("out_vec", i, act(i), exp_vec(p[i], nit(i)));
      if (dn[i] === 1'b1) begin
        j = find(i);
        checks++;
        if (j < 0) begin
          fails++;
          $display("FAIL done_unexpected inst=%0d cycle=%0d got=done want=no_done", i, cyc + 1);
        end else begin
          if (sbq[j].cyc != cyc + 1) begin
            fails++;
            $display("FAIL done_cycle inst=%0d got=%0d want=%0d", i, cyc + 1, sbq[j].cyc);
          end
          sbq.delete(j);
        end
      end
    end
  end

  task automatic cycles(int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic wait_pos(int target, int maxc, string name);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < maxc && !hit; k++) begin
      @(negedge clk);
      if (p[0] == target) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      fails++;
      $display("FAIL %s got=timeout want=position_%0d", name, target);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cmp("reset_outputs", i, act(i), 13'd0);
    cycles(3);
    rst = 1'b0;

    // Single divide.
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(22);

    // Back-to-back divides from a held start.
    start = 1'b1;
    cycles(30);
    start = 1'b0;
    cycles(22);

    // Abort in the second ITER_Q, then a clean divide.
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_pos(5, 20, "wait_iterq2");
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    cycles(3);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(22);

    // Asynchronous reset during REM, start right at release.
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_pos(9, 20, "wait_rem");
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) cmp("async_reset", i, act(i), 13'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(22);

    // Random start/abort traffic.
    for (int k = 0; k < 500; k++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      cycles(1);
    end
    start = 1'b0;
    abort = 1'b0;
    cycles(25);

    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL pending_done got=%0d want=0", sbq.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
